// File: rtl/arith_pkg.sv
// Shared encodings and the B-operand select used by the digit-serial arithmetic unit.
package arith_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_XFER = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Per-bit B-operand select; applied across the operand width at accept.
    function automatic logic bmux_bit(input logic [1:0] op, input logic b);
        logic r;
        unique case (op)
            OP_ADD:  r = b;
            OP_ADDC: r = ~b;
            OP_XFER: r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arith_slice.sv
// Combinational SLICE-bit adder slice; also reports the carry into its MSB for overflow.
module arith_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
    assign sum_o  = full[SLICE-1:0];
    assign cout_o = full[SLICE];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the XOR.
    assign cmsb_o = a_i[SLICE-1] ^ b_i[SLICE-1] ^ full[SLICE-1];

endmodule

// File: rtl/digit_serial_arith_unit.sv
// Digit-serial add/subtract/transfer/decrement unit: SLICE bits per cycle through a
// registered carry, with valid/ready handshakes and an accumulate path from f.
module digit_serial_arith_unit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s1,
    input  logic             s0,
    input  logic             cin,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, res_q, f_q;
    logic              carry_q, cout_q, ovf_q;
    logic [CW-1:0]     cnt_q;

    logic [WIDTH-1:0]  a_op, b_op, res_d;
    logic [SLICE-1:0]  sum;
    logic              slice_cout, slice_cmsb;

    always_comb begin
        a_op = acc_sel ? f_q : a;
        b_op = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            b_op[i] = bmux_bit({s1, s0}, b[i]);
        end
    end

    arith_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (a_q[SLICE-1:0]),
        .b_i    (b_q[SLICE-1:0]),
        .cin_i  (carry_q),
        .sum_o  (sum),
        .cout_o (slice_cout),
        .cmsb_o (slice_cmsb)
    );

    // New slice enters at the top; after N cycles the first slice has reached bit 0.
    logic [WIDTH+SLICE-1:0] res_cat;
    assign res_cat = {sum, res_q};
    assign res_d   = res_cat[WIDTH+SLICE-1:SLICE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            f_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_op;
                        b_q     <= b_op;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    res_q   <= res_d;
                    carry_q <= slice_cout;
                    if (cnt_q == CW'(N - 1)) begin
                        f_q     <= res_d;
                        cout_q  <= slice_cout;
                        ovf_q   <= slice_cmsb ^ slice_cout;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign f         = f_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_arith_unit.sv
// Scoreboard bench for digit_serial_arith_unit at WIDTH=16, SLICE=4.
module tb_digit_serial_arith_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;
    localparam int unsigned N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b;
    logic             s1, s0, cin, acc_sel;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] f;
    logic             cout, ovf, busy;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_f;
    int               n_checks = 0;
    int               n_fail   = 0;

    digit_serial_arith_unit #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s1        (s1),
        .s0        (s0),
        .cin       (cin),
        .acc_sel   (acc_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] aop, input logic [WIDTH-1:0] bv,
                                   input logic [1:0] s, input logic c);
        logic [WIDTH-1:0] bm;
        logic [WIDTH:0]   sum;
        exp_t             e;
        case (s)
            2'b00:   bm = bv;
            2'b01:   bm = ~bv;
            2'b10:   bm = '0;
            default: bm = '1;
        endcase
        sum    = {1'b0, aop} + {1'b0, bm} + {{WIDTH{1'b0}}, c};
        e.f    = sum[WIDTH-1:0];
        e.cout = sum[WIDTH];
        e.ovf  = (aop[WIDTH-1] ^ bm[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
        return e;
    endfunction

    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [1:0] s, input logic c, input logic acc, input int hold);
        exp_t e, got_e;
        int   lat;
        e = model(acc ? model_f : av, bv, s, c);
        check_eq("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        {s1, s0}  = s;
        cin       = c;
        acc_sel   = acc;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(e);
        model_f = e.f;
        check_eq("busy_run", busy, 1);
        check_eq("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, N);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a        = 16'hDEAD;
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_f", f, e.f);
            check_eq("hold_ovf", ovf, e.ovf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check_eq("f", f, got_e.f);
            check_eq("cout", cout, got_e.cout);
            check_eq("ovf", ovf, got_e.ovf);
        end
        @(posedge clk); #1;
        check_eq("out_valid_drop", out_valid, 0);
        check_eq("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        s1 = 1'b0; s0 = 1'b0; cin = 1'b0; acc_sel = 1'b0; out_ready = 1'b1;
        model_f = '0;
        #12;
        check_eq("rst_f", f, 0);
        check_eq("rst_cout", cout, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(16'h1234, 16'h0FCC, 2'b00, 1'b0, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 2'b00, 1'b0, 1'b1, 0);
        do_op(16'h0005, 16'h0007, 2'b01, 1'b1, 1'b0, 0);
        do_op(16'h0007, 16'h0005, 2'b01, 1'b1, 1'b0, 0);
        do_op(16'h0000, 16'h1234, 2'b11, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h5555, 2'b10, 1'b1, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, 5);

        // Abort during the second RUN cycle; nothing is pushed for this operation.
        in_valid = 1'b1; a = 16'h4321; b = 16'h1111; {s1, s0} = 2'b00; cin = 1'b0;
        acc_sel = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("abort_f", f, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_busy", busy, 0);
        model_f = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(16'h0001, 16'h0001, 2'b00, 1'b0, 1'b0, 0);
        do_op(16'h0000, 16'h0005, 2'b00, 1'b0, 1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            do_op(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        check_eq("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
